idct_mac_accum: RTL and testbench
=================================

# idct_mac_accum

Downstream consumer of the 16-bit configurable multiplier wrapper in the IDCT datapath. Takes the wrapper's registered 32-bit product `P` each valid cycle, sums groups of `TAPS` products into one 1-D IDCT output, then rounds, shifts by a pass-dependent amount and saturates to `OUT_BITWIDTH`. It also tracks each output's index within the 8x8 block and flags block completion, saturation and aborted groups for the IDCT controller.

## Interface
- `IN_BITWIDTH`, 32, width of incoming product `P` (signed)
- `ACC_BITWIDTH`, 40, accumulator width (signed); must be >= IN_BITWIDTH + log2(TAPS)
- `OUT_BITWIDTH`, 16, output sample width (signed)
- `TAPS`, 8, products summed per output
- `ROW_SHIFT`, 8, rounding right-shift in row pass
- `COL_SHIFT`, 12, rounding right-shift in column pass
- `clk` in 1 — single clock, all state on rising edge
- `rstP` in 1 — reset, synchronous, active-high
- `state` in 3 — controller state; 3'b010 = row pass, 3'b011 or 3'b100 = column pass, all others inactive
- `P` in IN_BITWIDTH — signed product from the multiplier wrapper
- `p_valid` in 1 — `P` holds a valid product this cycle
- `y` out OUT_BITWIDTH — rounded, saturated output sample
- `y_valid` out 1 — one-cycle pulse, `y`/`y_index`/`sat` valid
- `y_index` out 6 — output position 0..63 within block
- `sat` out 1 — `y` was clipped (qualified by `y_valid`)
- `block_done` out 1 — pulses with the 64th `y_valid` of a block
- `err_partial` out 1 — sticky; a group was aborted before TAPS products

## Operation
- Pass category: ROW (010), COL (011/100), NONE (other). Category latched at tap 0 of each group.
- Tap counter 0..TAPS-1. On `p_valid` with category != NONE: tap 0 loads acc = sext(P); taps 1..TAPS-1 add acc += sext(P). `p_valid` with category NONE is ignored.
- On tap TAPS-1: sum = acc + sext(P) (combinational); sh = ROW_SHIFT or COL_SHIFT per latched category; r = (sum + 2^(sh-1)) >>> sh (arithmetic; ties round toward +inf). If r > 2^(OUT-1)-1, y = max, sat=1; if r < -2^(OUT-1), y = min, sat=1; else y = r, sat=0. Tap counter returns to 0.
- Abort: while tap != 0, if current category differs from latched category (including going NONE), discard partial sum, tap←0, err_partial←1. If `p_valid` is high in the abort cycle and the new category is active, that product is tap 0 of a new group. Aborted groups do not advance `y_index`.
- `y_index` increments after each `y_valid`, wrapping 63→0; `block_done` high in the cycle `y_valid` carries index 63.
- `err_partial` clears only on `rstP`.
- Reset: `y`=0, `y_valid`=0, `y_index`=0, `sat`=0, `block_done`=0, `err_partial`=0, acc=0, tap=0, latched category NONE. Reset mid-group discards the group; no output is produced for it.

## Timing
- Products may arrive back-to-back or with arbitrary gaps; no back-pressure.
- Latency: last-tap `p_valid` in cycle n → `y_valid` in cycle n+1. `y`, `sat`, `y_index` registered and held until the next `y_valid`.
- Max throughput: one output per TAPS cycles; tap 0 of the next group may arrive in the same cycle as the previous group's `y_valid`.
- `rstP` overrides everything in the same edge, including a coincident last tap.

## Test plan
- Row pass, 8 products of 256 → sum 2048, y = (2048+128)>>8 = 8, sat=0, y_index=0, y_valid one cycle after 8th tap.
- Column pass (state 011 then 100 mid-group, no abort), 8 products of -4096 → sum -32768, y = (-30720)>>>12 = -8, sat=0.
- Rounding ties, row pass: {128,0×7} → y=1; {-128,0×7} → y=0.
- Saturation, row pass: 8 × 0x7FFF_FFFF → y=32767, sat=1; 8 × 0x8000_0000 → y=-32768, sat=1.
- Abort: 3 row taps then state→000 → no y_valid, err_partial=1; next 8 row taps of 256 → y=8 at unchanged y_index; reset then clears err_partial.
- Block sweep: 64 groups → y_index 0..63, block_done only with index 63, 65th output at index 0; rstP asserted at tap 5 of a group → all outputs 0, next full group gives correct y at index 0.

Source files
------------

// File: rtl/idct_mac_accum_if.sv
// Product-in / sample-out bus between the multiplier wrapper, the
// accumulator and the IDCT controller.
interface idct_mac_accum_if #(
  parameter int IN_BITWIDTH  = 32,
  parameter int OUT_BITWIDTH = 16
);
  // Producer side: controller state plus the wrapper's registered product
  logic [2:0]                     state;
  logic signed [IN_BITWIDTH-1:0]  P;
  logic                           p_valid;

  // Consumer side: rounded/saturated sample and status
  logic signed [OUT_BITWIDTH-1:0] y;
  logic                           y_valid;
  logic [5:0]                     y_index;
  logic                           sat;
  logic                           block_done;
  logic                           err_partial;

  // Drives products, observes results
  modport master (
    output state, P, p_valid,
    input  y, y_valid, y_index, sat, block_done, err_partial
  );

  // The accumulator itself
  modport slave (
    input  state, P, p_valid,
    output y, y_valid, y_index, sat, block_done, err_partial
  );
endinterface

// File: rtl/idct_mac_accum.sv
// Sums TAPS signed products into one 1-D IDCT output, then rounds
// (ties toward +inf), shifts by a pass-dependent amount and saturates.
// Tracks the output position within the 8x8 block and flags aborted groups.
module idct_mac_accum #(
  parameter int IN_BITWIDTH  = 32,
  parameter int ACC_BITWIDTH = 40,
  parameter int OUT_BITWIDTH = 16,
  parameter int TAPS         = 8,
  parameter int ROW_SHIFT    = 8,
  parameter int COL_SHIFT    = 12
) (
  input logic               clk,
  input logic               rstP,
  idct_mac_accum_if.slave   bus
);

  // Pass category; only ROW and COL accumulate
  typedef enum logic [1:0] {
    CAT_NONE = 2'd0,
    CAT_ROW  = 2'd1,
    CAT_COL  = 2'd2
  } cat_e;

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  // One guard bit above the accumulator so adding the rounding constant
  // can never wrap, even for a full-scale sum.
  localparam int RW = ACC_BITWIDTH + 1;
  localparam logic signed [RW-1:0] ROW_HALF = RW'(64'd1 << (ROW_SHIFT - 1));
  localparam logic signed [RW-1:0] COL_HALF = RW'(64'd1 << (COL_SHIFT - 1));
  localparam logic signed [RW-1:0] Y_MAX    = RW'((64'sd1 <<< (OUT_BITWIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] Y_MIN    = RW'(-(64'sd1 <<< (OUT_BITWIDTH - 1)));

  // State registers and their next values
  cat_e                           cat_q, cat_d;
  logic [TAP_W-1:0]               tap_q, tap_d;
  logic signed [ACC_BITWIDTH-1:0] acc_q, acc_d;
  logic signed [OUT_BITWIDTH-1:0] y_q, y_d;
  logic                           y_valid_q, y_valid_d;
  logic                           sat_q, sat_d;
  logic [5:0]                     y_index_q, y_index_d;
  logic [5:0]                     cnt_q, cnt_d;
  logic                           block_done_q, block_done_d;
  logic                           err_q, err_d;

  // Datapath intermediates
  cat_e                           cat_in;
  cat_e                           cat_eff;
  logic                           abort;
  logic [TAP_W-1:0]               tap_eff;
  logic signed [ACC_BITWIDTH-1:0] p_ext;
  logic signed [ACC_BITWIDTH-1:0] acc_base;
  logic signed [ACC_BITWIDTH-1:0] sum;
  logic signed [RW-1:0]           sum_ext;
  logic signed [RW-1:0]           r_row;
  logic signed [RW-1:0]           r_col;
  logic signed [RW-1:0]           r_sel;

  // Decode controller state into a pass category
  always_comb begin
    cat_in = CAT_NONE;
    case (bus.state)
      3'b010:         cat_in = CAT_ROW;
      3'b011, 3'b100: cat_in = CAT_COL;
      default:        cat_in = CAT_NONE;
    endcase
  end

  // Sum path: a group in flight is aborted when the pass changes, in which
  // case the incoming product (if any) starts a fresh group at tap 0.
  always_comb begin
    abort    = (tap_q != '0) && (cat_in != cat_q);
    tap_eff  = abort ? '0 : tap_q;
    cat_eff  = (tap_eff == '0) ? cat_in : cat_q;
    p_ext    = ACC_BITWIDTH'(bus.P);
    acc_base = (tap_eff == '0) ? '0 : acc_q;
    sum      = acc_base + p_ext;
    sum_ext  = RW'(sum);
    r_row    = (sum_ext + ROW_HALF) >>> ROW_SHIFT;
    r_col    = (sum_ext + COL_HALF) >>> COL_SHIFT;
    r_sel    = (cat_eff == CAT_COL) ? r_col : r_row;
  end

  // Next-state: tap sequencing, output formation, index and status flags
  always_comb begin
    cat_d        = cat_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    y_d          = y_q;
    y_valid_d    = 1'b0;
    sat_d        = sat_q;
    y_index_d    = y_index_q;
    cnt_d        = cnt_q;
    block_done_d = 1'b0;
    err_d        = err_q;

    if (abort) begin
      err_d = 1'b1;
      tap_d = '0;
      acc_d = '0;
      cat_d = CAT_NONE;
    end

    if (bus.p_valid && (cat_in != CAT_NONE)) begin
      if (tap_eff == LAST_TAP) begin
        // Last tap: emit the rounded, saturated result next cycle
        tap_d     = '0;
        acc_d     = '0;
        cat_d     = CAT_NONE;
        y_valid_d = 1'b1;
        y_index_d = cnt_q;
        cnt_d     = cnt_q + 6'd1;
        block_done_d = (cnt_q == 6'd63);
        if (r_sel > Y_MAX) begin
          y_d   = Y_MAX[OUT_BITWIDTH-1:0];
          sat_d = 1'b1;
        end else if (r_sel < Y_MIN) begin
          y_d   = Y_MIN[OUT_BITWIDTH-1:0];
          sat_d = 1'b1;
        end else begin
          y_d   = r_sel[OUT_BITWIDTH-1:0];
          sat_d = 1'b0;
        end
      end else begin
        // Intermediate tap: keep accumulating under the latched category
        tap_d = tap_eff + TAP_W'(1);
        acc_d = sum;
        cat_d = cat_eff;
      end
    end
  end

  // State register; reset discards any group in flight
  always_ff @(posedge clk) begin
    if (rstP) begin
      cat_q        <= CAT_NONE;
      tap_q        <= '0;
      acc_q        <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      sat_q        <= 1'b0;
      y_index_q    <= '0;
      cnt_q        <= '0;
      block_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cat_q        <= cat_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      sat_q        <= sat_d;
      y_index_q    <= y_index_d;
      cnt_q        <= cnt_d;
      block_done_q <= block_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.y           = y_q;
  assign bus.y_valid     = y_valid_q;
  assign bus.sat         = sat_q;
  assign bus.y_index     = y_index_q;
  assign bus.block_done  = block_done_q;
  assign bus.err_partial = err_q;

endmodule

// File: tb/tb_idct_mac_accum.sv
// Directed bench for idct_mac_accum with hand-computed expectations.
module tb_idct_mac_accum;

  logic clk;
  logic rstP;
  int   errors;
  int   checks;

  idct_mac_accum_if bus ();

  idct_mac_accum dut (
    .clk  (clk),
    .rstP (rstP),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One product, captured at the next rising edge; returns 1 time unit later
  task automatic tap(input logic [2:0] st, input logic signed [31:0] p);
    bus.state   = st;
    bus.P       = p;
    bus.p_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.p_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full group: first product then seven copies of rest
  task automatic group(input logic [2:0] st, input logic signed [31:0] first,
                       input logic signed [31:0] rest);
    tap(st, first);
    for (int i = 1; i < 7; i++) tap(st, rest);
    check("no_early_valid", bus.y_valid, 0);
    tap(st, rest);
  endtask

  task automatic check_out(input string tag, input int y_exp, input int sat_exp,
                           input int idx_exp);
    check({tag, "_valid"}, bus.y_valid, 1);
    check({tag, "_y"}, $signed(bus.y), y_exp);
    check({tag, "_sat"}, bus.sat, sat_exp);
    check({tag, "_idx"}, bus.y_index, idx_exp);
    $display("txn %s: y=%0d sat=%0b idx=%0d done=%0b err=%0b", tag,
             $signed(bus.y), bus.sat, bus.y_index, bus.block_done, bus.err_partial);
  endtask

  task automatic do_reset();
    rstP = 1'b1;
    @(posedge clk);
    #1;
    rstP = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    bus.state   = 3'b000;
    bus.P       = '0;
    bus.p_valid = 1'b0;
    rstP        = 1'b1;
    idle(2);
    rstP = 1'b0;

    // Reset state
    check("rst_y", $signed(bus.y), 0);
    check("rst_valid", bus.y_valid, 0);
    check("rst_idx", bus.y_index, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_done", bus.block_done, 0);
    check("rst_err", bus.err_partial, 0);

    // NONE-category products are ignored
    tap(3'b000, 32'sd1000);
    tap(3'b111, 32'sd1000);
    check("none_ignored", bus.y_valid, 0);

    // Row pass 8x256 -> 8
    group(3'b010, 32'sd256, 32'sd256);
    check_out("row256", 8, 0, 0);
    idle(1);
    check("valid_pulse", bus.y_valid, 0);
    check("y_held", $signed(bus.y), 8);

    // Column pass, state 011 then 100 mid-group, 8x-4096 -> -8
    for (int i = 0; i < 8; i++) tap((i < 4) ? 3'b011 : 3'b100, -32'sd4096);
    check_out("col", -8, 0, 1);

    // Rounding ties
    group(3'b010, 32'sd128, 32'sd0);
    check_out("tie_pos", 1, 0, 2);
    group(3'b010, -32'sd128, 32'sd0);
    check_out("tie_neg", 0, 0, 3);

    // Saturation
    group(3'b010, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF);
    check_out("sat_pos", 32767, 1, 4);
    group(3'b010, 32'sh8000_0000, 32'sh8000_0000);
    check_out("sat_neg", -32768, 1, 5);

    // Abort by going inactive
    for (int i = 0; i < 3; i++) tap(3'b010, 32'sd256);
    bus.state = 3'b000;
    idle(1);
    check("abort_no_valid", bus.y_valid, 0);
    check("abort_err", bus.err_partial, 1);
    idle(8);
    check("abort_no_late_valid", bus.y_valid, 0);
    group(3'b010, 32'sd256, 32'sd256);
    check_out("after_abort", 8, 0, 6);

    // Abort by switching to column with a product: it becomes tap 0
    tap(3'b010, 32'sd256);
    tap(3'b010, 32'sd256);
    tap(3'b011, -32'sd4096);
    check("switch_no_valid", bus.y_valid, 0);
    for (int i = 0; i < 7; i++) tap(3'b011, -32'sd4096);
    check_out("switch_col", -8, 0, 7);
    check("err_sticky", bus.err_partial, 1);

    // Reset clears sticky error and index
    do_reset();
    check("rst2_err", bus.err_partial, 0);
    check("rst2_idx", bus.y_index, 0);
    check("rst2_y", $signed(bus.y), 0);

    // Block sweep: group g sums to 256*g -> y = g
    for (int g = 0; g < 64; g++) begin
      group(3'b010, 32'(g * 32), 32'(g * 32));
      check("sweep_valid", bus.y_valid, 1);
      check("sweep_y", $signed(bus.y), g);
      check("sweep_idx", bus.y_index, g);
      check("sweep_done", bus.block_done, (g == 63) ? 1 : 0);
      $display("txn sweep g=%0d: y=%0d idx=%0d done=%0b", g, $signed(bus.y),
               bus.y_index, bus.block_done);
    end
    idle(1);
    check("done_pulse", bus.block_done, 0);
    group(3'b010, 32'sd256, 32'sd256);
    check_out("wrap", 8, 0, 0);
    check("wrap_done", bus.block_done, 0);

    // Reset coincident with tap 5 of a group
    for (int i = 0; i < 5; i++) tap(3'b010, 32'sh7FFF_FFFF);
    bus.state   = 3'b010;
    bus.P       = 32'sh7FFF_FFFF;
    bus.p_valid = 1'b1;
    rstP        = 1'b1;
    @(posedge clk);
    #1;
    rstP        = 1'b0;
    bus.p_valid = 1'b0;
    check("midrst_y", $signed(bus.y), 0);
    check("midrst_valid", bus.y_valid, 0);
    check("midrst_idx", bus.y_index, 0);
    check("midrst_sat", bus.sat, 0);
    check("midrst_err", bus.err_partial, 0);
    tap(3'b010, 32'sh7FFF_FFFF);
    tap(3'b010, 32'sh7FFF_FFFF);
    idle(2);
    check("midrst_no_output", bus.y_valid, 0);
    // Two stray taps above started a fresh group; drop them cleanly
    do_reset();
    group(3'b010, 32'sd256, 32'sd256);
    check_out("post_rst", 8, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
